// File: rtl/boot_seq_ctrl_pkg.sv
// Shared definitions for the AS2650 boot ROM overlay sequencer.
package boot_seq_ctrl_pkg;

    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned ROM_WINDOW   = 256;
    localparam int unsigned ROM_AW       = $clog2(ROM_WINDOW);
    localparam int unsigned ROM_SIZE_DEF = 170;

    typedef enum logic [1:0] {
        ST_HOLD       = 2'd0,
        ST_ROM_ACTIVE = 2'd1,
        ST_HANDOFF    = 2'd2,
        ST_DONE       = 2'd3
    } boot_state_e;

endpackage

// File: rtl/boot_wdt.sv
// Saturating up-counter with enable/clear; flags the cycle the count reaches all-ones.
module boot_wdt #(
    parameter int unsigned W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_term_c
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_PRE = CNT_MAX - W'(1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // High while enabled and the next increment lands on (or sits at) all-ones
    assign o_term_c = i_en && !i_clr && (r_cnt >= CNT_PRE);

endmodule

// File: rtl/boot_seq_ctrl.sv
// Boot ROM overlay sequencer: post-reset CPU stall, ROM read wait states, handoff to external memory.
module boot_seq_ctrl
    import boot_seq_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned ROM_SIZE    = ROM_SIZE_DEF,
    parameter int unsigned TIMEOUT_W   = 20
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              boot_en,
    input  logic [ADDR_W-1:0] ram_start,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_mio,
    output logic [ROM_AW-1:0] last_addr,
    output logic              rom_sel,
    output logic              rd_ready,
    output logic              cpu_hold,
    output logic              ext_mem_en,
    output logic              booted,
    output logic              boot_timeout
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    boot_state_e       r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [ROM_AW-1:0] r_last_addr;
    logic              r_rom_sel;
    logic              r_rd_ready;
    logic              r_ack_pend;
    logic              r_cpu_hold;
    logic              r_ext_mem_en;
    logic              r_booted;
    logic              r_boot_timeout;

    logic w_mem_rd;
    logic w_rom_range;
    logic w_rom_hit;
    logic w_handoff;
    logic w_wdt_en;
    logic w_wdt_term;

    assign w_mem_rd    = cpu_rd && cpu_mio;
    assign w_rom_range = cpu_addr < ADDR_W'(ROM_SIZE);
    assign w_handoff   = w_mem_rd && (cpu_addr == ram_start);
    // A new ROM read is accepted only once the previous one is fully acknowledged
    assign w_rom_hit   = w_mem_rd && w_rom_range && !r_ack_pend && !r_rd_ready;
    assign w_wdt_en    = (r_state == ST_ROM_ACTIVE);

    boot_wdt #(
        .W (TIMEOUT_W)
    ) u_wdt (
        .clk      (wb_clk_i),
        .rst_n    (rst_n),
        .i_en     (w_wdt_en),
        .i_clr    (!w_wdt_en),
        .o_term_c (w_wdt_term)
    );

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_HOLD;
            r_hold_cnt     <= '0;
            r_last_addr    <= '0;
            r_rom_sel      <= 1'b0;
            r_rd_ready     <= 1'b0;
            r_ack_pend     <= 1'b0;
            r_cpu_hold     <= 1'b1;
            r_ext_mem_en   <= 1'b0;
            r_booted       <= 1'b0;
            r_boot_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        r_cpu_hold <= 1'b0;
                        if (boot_en) begin
                            r_state <= ST_ROM_ACTIVE;
                        end else begin
                            r_state      <= ST_DONE;
                            r_booted     <= 1'b1;
                            r_ext_mem_en <= 1'b1;
                        end
                    end
                end

                ST_ROM_ACTIVE: begin
                    // Handoff outranks both the watchdog and a ROM hit
                    if (w_handoff) begin
                        r_state      <= ST_HANDOFF;
                        r_rom_sel    <= 1'b0;
                        r_rd_ready   <= 1'b0;
                        r_ack_pend   <= 1'b0;
                        r_ext_mem_en <= 1'b1;
                    end else if (w_wdt_term) begin
                        r_state        <= ST_DONE;
                        r_boot_timeout <= 1'b1;
                        r_booted       <= 1'b1;
                        r_rom_sel      <= 1'b0;
                        r_rd_ready     <= 1'b0;
                        r_ack_pend     <= 1'b0;
                        r_ext_mem_en   <= 1'b1;
                    end else begin
                        r_ext_mem_en <= cpu_mio && !w_rom_range;
                        r_rd_ready   <= r_ack_pend;
                        if (w_rom_hit) begin
                            r_last_addr <= cpu_addr[ROM_AW-1:0];
                            r_rom_sel   <= 1'b1;
                            r_ack_pend  <= 1'b1;
                        end else begin
                            r_ack_pend <= 1'b0;
                            if (!cpu_rd) begin
                                r_rom_sel <= 1'b0;
                            end
                        end
                    end
                end

                ST_HANDOFF: begin
                    r_state      <= ST_DONE;
                    r_booted     <= 1'b1;
                    r_ext_mem_en <= 1'b1;
                end

                ST_DONE: begin
                    r_ext_mem_en <= 1'b1;
                    r_rom_sel    <= 1'b0;
                    r_rd_ready   <= 1'b0;
                    r_ack_pend   <= 1'b0;
                    r_cpu_hold   <= 1'b0;
                end

                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign last_addr    = r_last_addr;
    assign rom_sel      = r_rom_sel;
    assign rd_ready     = r_rd_ready;
    assign cpu_hold     = r_cpu_hold;
    assign ext_mem_en   = r_ext_mem_en;
    assign booted       = r_booted;
    assign boot_timeout = r_boot_timeout;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Directed testbench for boot_seq_ctrl; a second instance with a 4-bit watchdog covers timeout.
module tb_boot_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic        boot_en;
    logic [15:0] ram_start;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_mio;

    logic [7:0] last_addr;
    logic       rom_sel, rd_ready, cpu_hold, ext_mem_en, booted, boot_timeout;
    logic [7:0] b_last_addr;
    logic       b_rom_sel, b_rd_ready, b_cpu_hold, b_ext_mem_en, b_booted, b_boot_timeout;

    int n_checks;
    int n_fail;

    boot_seq_ctrl #(.HOLD_CYCLES(16), .ROM_SIZE(170), .TIMEOUT_W(8)) u_dut (
        .wb_clk_i(clk), .rst_n(rst_n), .boot_en(boot_en), .ram_start(ram_start),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_mio(cpu_mio),
        .last_addr(last_addr), .rom_sel(rom_sel), .rd_ready(rd_ready), .cpu_hold(cpu_hold),
        .ext_mem_en(ext_mem_en), .booted(booted), .boot_timeout(boot_timeout)
    );

    boot_seq_ctrl #(.HOLD_CYCLES(16), .ROM_SIZE(170), .TIMEOUT_W(4)) u_dut_wdt (
        .wb_clk_i(clk), .rst_n(rst2_n), .boot_en(boot_en), .ram_start(ram_start),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_mio(cpu_mio),
        .last_addr(b_last_addr), .rom_sel(b_rom_sel), .rd_ready(b_rd_ready), .cpu_hold(b_cpu_hold),
        .ext_mem_en(b_ext_mem_en), .booted(b_booted), .boot_timeout(b_boot_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cpu_rd   = 1'b0;
        cpu_mio  = 1'b1;
        cpu_addr = 16'h0000;
    endtask

    // Reset the main instance and run it through the 16-cycle hold
    task automatic boot_main(input logic en);
        boot_en = en;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) step();
    endtask

    task automatic test_reset();
        idle_bus();
        boot_en   = 1'b1;
        ram_start = 16'h0400;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b exp 1", cpu_hold); end
        n_checks++; if (last_addr !== 8'h00) begin n_fail++; $display("FAIL reset_last_addr: got %h exp 00", last_addr); end
        n_checks++; if ({rom_sel, rd_ready, ext_mem_en, booted, boot_timeout} !== 5'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b exp 00000", {rom_sel, rd_ready, ext_mem_en, booted, boot_timeout}); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++; if (cpu_hold !== (i < 15)) begin n_fail++; $display("FAIL hold_cpu_hold[%0d]: got %b exp %b", i, cpu_hold, (i < 15)); end
            n_checks++; if (ext_mem_en !== 1'b0) begin n_fail++; $display("FAIL hold_ext_mem_en[%0d]: got %b exp 0", i, ext_mem_en); end
        end
        n_checks++; if (booted !== 1'b0) begin n_fail++; $display("FAIL hold_booted: got %b exp 0", booted); end
    endtask

    task automatic test_rom_read();
        cpu_addr = 16'h0004; cpu_mio = 1'b1; cpu_rd = 1'b1;
        step();
        n_checks++; if (last_addr !== 8'h04) begin n_fail++; $display("FAIL rd_last_addr: got %h exp 04", last_addr); end
        n_checks++; if (rom_sel !== 1'b1) begin n_fail++; $display("FAIL rd_rom_sel_e1: got %b exp 1", rom_sel); end
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_e1: got %b exp 0", rd_ready); end
        step();
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_e2: got %b exp 1", rd_ready); end
        step();
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_e3: got %b exp 0", rd_ready); end
        n_checks++; if (rom_sel !== 1'b1) begin n_fail++; $display("FAIL rd_rom_sel_held: got %b exp 1", rom_sel); end
        cpu_rd = 1'b0;
        step();
        n_checks++; if (rom_sel !== 1'b0) begin n_fail++; $display("FAIL rd_rom_sel_drop: got %b exp 0", rom_sel); end
        n_checks++; if (ext_mem_en !== 1'b0) begin n_fail++; $display("FAIL rd_ext_mem_en: got %b exp 0", ext_mem_en); end
    endtask

    task automatic test_back_to_back();
        cpu_addr = 16'h0010; cpu_rd = 1'b1;
        step();
        step();
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_first: got %b exp 1", rd_ready); end
        cpu_addr = 16'h0020;
        step();
        n_checks++; if (last_addr !== 8'h10) begin n_fail++; $display("FAIL b2b_last_blocked: got %h exp 10", last_addr); end
        step();
        n_checks++; if (last_addr !== 8'h20) begin n_fail++; $display("FAIL b2b_last_second: got %h exp 20", last_addr); end
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_gap: got %b exp 0", rd_ready); end
        n_checks++; if (rom_sel !== 1'b1) begin n_fail++; $display("FAIL b2b_rom_sel: got %b exp 1", rom_sel); end
        step();
        n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_second: got %b exp 1", rd_ready); end
        cpu_rd = 1'b0;
        step();
        n_checks++; if (rom_sel !== 1'b0) begin n_fail++; $display("FAIL b2b_rom_sel_drop: got %b exp 0", rom_sel); end
    endtask

    task automatic test_rom_boundary();
        cpu_addr = 16'h00A9; cpu_rd = 1'b1;
        step();
        n_checks++; if (last_addr !== 8'hA9) begin n_fail++; $display("FAIL bnd_last_169: got %h exp a9", last_addr); end
        n_checks++; if (ext_mem_en !== 1'b0) begin n_fail++; $display("FAIL bnd_ext_169: got %b exp 0", ext_mem_en); end
        step();
        cpu_rd = 1'b0;
        step();
        cpu_addr = 16'h00AA; cpu_rd = 1'b1;
        step();
        n_checks++; if (last_addr !== 8'hA9) begin n_fail++; $display("FAIL bnd_last_170: got %h exp a9", last_addr); end
        n_checks++; if (rom_sel !== 1'b0) begin n_fail++; $display("FAIL bnd_rom_sel_170: got %b exp 0", rom_sel); end
        n_checks++; if (ext_mem_en !== 1'b1) begin n_fail++; $display("FAIL bnd_ext_170: got %b exp 1", ext_mem_en); end
        step();
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL bnd_ready_170: got %b exp 0", rd_ready); end
        idle_bus();
        step();
    endtask

    task automatic test_io_cycle();
        cpu_addr = 16'h0008; cpu_mio = 1'b0; cpu_rd = 1'b1;
        step();
        n_checks++; if (last_addr !== 8'hA9) begin n_fail++; $display("FAIL io_last_addr: got %h exp a9", last_addr); end
        n_checks++; if ({rom_sel, ext_mem_en} !== 2'b00) begin n_fail++; $display("FAIL io_sel_ext: got %b exp 00", {rom_sel, ext_mem_en}); end
        step();
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL io_rd_ready: got %b exp 0", rd_ready); end
        idle_bus();
        step();
    endtask

    task automatic test_handoff();
        cpu_addr = 16'h0400; cpu_rd = 1'b1;
        step();
        n_checks++; if ({rom_sel, ext_mem_en} !== 2'b01) begin n_fail++; $display("FAIL ho_sel_ext: got %b exp 01", {rom_sel, ext_mem_en}); end
        n_checks++; if (booted !== 1'b0) begin n_fail++; $display("FAIL ho_booted_early: got %b exp 0", booted); end
        step();
        n_checks++; if (booted !== 1'b1) begin n_fail++; $display("FAIL ho_booted: got %b exp 1", booted); end
        n_checks++; if (boot_timeout !== 1'b0) begin n_fail++; $display("FAIL ho_timeout: got %b exp 0", boot_timeout); end
        cpu_rd = 1'b0;
        step();
        cpu_addr = 16'h0004; cpu_rd = 1'b1;
        step();
        n_checks++; if (rom_sel !== 1'b0) begin n_fail++; $display("FAIL done_rom_sel: got %b exp 0", rom_sel); end
        n_checks++; if (ext_mem_en !== 1'b1) begin n_fail++; $display("FAIL done_ext: got %b exp 1", ext_mem_en); end
        n_checks++; if (last_addr !== 8'hA9) begin n_fail++; $display("FAIL done_last_kept: got %h exp a9", last_addr); end
        step();
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL done_rd_ready: got %b exp 0", rd_ready); end
        idle_bus();
    endtask

    task automatic test_handoff_priority();
        ram_start = 16'h0010;
        boot_main(1'b1);
        cpu_addr = 16'h0010; cpu_rd = 1'b1;
        step();
        n_checks++; if ({rom_sel, ext_mem_en} !== 2'b01) begin n_fail++; $display("FAIL prio_sel_ext: got %b exp 01", {rom_sel, ext_mem_en}); end
        n_checks++; if (last_addr !== 8'h00) begin n_fail++; $display("FAIL prio_last_addr: got %h exp 00", last_addr); end
        step();
        n_checks++; if (booted !== 1'b1) begin n_fail++; $display("FAIL prio_booted: got %b exp 1", booted); end
        idle_bus();
        ram_start = 16'h0400;
    endtask

    task automatic test_no_boot();
        boot_en = 1'b0;
        rst_n   = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        n_checks++; if ({cpu_hold, booted} !== 2'b10) begin n_fail++; $display("FAIL nb_hold15: got %b exp 10", {cpu_hold, booted}); end
        step();
        n_checks++; if ({cpu_hold, booted, ext_mem_en} !== 3'b011) begin n_fail++; $display("FAIL nb_done: got %b exp 011", {cpu_hold, booted, ext_mem_en}); end
        cpu_addr = 16'h0004; cpu_rd = 1'b1;
        step();
        n_checks++; if (rom_sel !== 1'b0) begin n_fail++; $display("FAIL nb_rom_sel: got %b exp 0", rom_sel); end
        step();
        n_checks++; if ({rd_ready, last_addr} !== 9'h000) begin n_fail++; $display("FAIL nb_ready_last: got %h exp 000", {rd_ready, last_addr}); end
        idle_bus();
        boot_en = 1'b1;
    endtask

    task automatic test_async_reset_mid_read();
        boot_main(1'b1);
        cpu_addr = 16'h0004; cpu_rd = 1'b1;
        step();
        n_checks++; if (rom_sel !== 1'b1) begin n_fail++; $display("FAIL ar_pre_rom_sel: got %b exp 1", rom_sel); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({cpu_hold, rom_sel, rd_ready, ext_mem_en, booted, boot_timeout} !== 6'b100000)
            begin n_fail++; $display("FAIL ar_flags: got %b exp 100000", {cpu_hold, rom_sel, rd_ready, ext_mem_en, booted, boot_timeout}); end
        n_checks++; if (last_addr !== 8'h00) begin n_fail++; $display("FAIL ar_last_addr: got %h exp 00", last_addr); end
        step();
        idle_bus();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL ar_hold15: got %b exp 1", cpu_hold); end
        step();
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL ar_hold16: got %b exp 0", cpu_hold); end
    endtask

    task automatic test_timeout();
        rst_n     = 1'b0;
        boot_en   = 1'b1;
        ram_start = 16'h0400;
        idle_bus();
        rst2_n = 1'b0;
        step();
        rst2_n = 1'b1;
        for (int i = 0; i < 16; i++) step();
        n_checks++; if (b_cpu_hold !== 1'b0) begin n_fail++; $display("FAIL to_hold_done: got %b exp 0", b_cpu_hold); end
        for (int i = 0; i < 13; i++) step();
        cpu_addr = 16'h0004; cpu_rd = 1'b1;
        step();
        n_checks++; if ({b_last_addr, b_rom_sel} !== 9'h009) begin n_fail++; $display("FAIL to_hit14: got %h exp 009", {b_last_addr, b_rom_sel}); end
        n_checks++; if ({b_boot_timeout, b_booted} !== 2'b00) begin n_fail++; $display("FAIL to_early14: got %b exp 00", {b_boot_timeout, b_booted}); end
        step();
        n_checks++; if ({b_boot_timeout, b_booted} !== 2'b11) begin n_fail++; $display("FAIL to_fire15: got %b exp 11", {b_boot_timeout, b_booted}); end
        n_checks++; if ({b_rd_ready, b_rom_sel, b_ext_mem_en} !== 3'b001) begin n_fail++; $display("FAIL to_abort: got %b exp 001", {b_rd_ready, b_rom_sel, b_ext_mem_en}); end
        step();
        n_checks++; if ({b_rd_ready, b_boot_timeout} !== 2'b01) begin n_fail++; $display("FAIL to_sticky: got %b exp 01", {b_rd_ready, b_boot_timeout}); end
        idle_bus();
        rst2_n = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish, got no end exp end");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        rst2_n   = 1'b0;
        idle_bus();
        boot_en   = 1'b1;
        ram_start = 16'h0400;
        test_reset();
        test_rom_read();
        test_back_to_back();
        test_rom_boundary();
        test_io_cycle();
        test_handoff();
        test_handoff_priority();
        test_no_boot();
        test_async_reset_mid_read();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_seq_ctrl.md
Name: boot_seq_ctrl

Overview:
- Sequences the boot ROM overlay for the AS2650 core. After reset it stalls the CPU, then maps the 256-byte boot ROM window at 0x0000 for memory reads.
- It drives the ROM's registered address, `last_addr`, and inserts one wait state per ROM read.
- It hands the bus over to external memory when the CPU first reads at `ram_start`, or when a watchdog expires.
- It sits between the CPU bus interface, `boot_rom` and the external-memory bus mux.

Parameters:
- HOLD_CYCLES, 16: CPU stall cycles after reset release, for strap/config settling.
- ROM_SIZE, 170: number of valid ROM bytes; memory reads at addr < ROM_SIZE hit the ROM while active.
- TIMEOUT_W, 20: watchdog counter width; timeout after 2^TIMEOUT_W - 1 cycles in ROM_ACTIVE.

Ports:
- wb_clk_i  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- boot_en  in  1  strap; 0 = skip ROM boot, go straight to DONE after hold
- ram_start  in  16  handoff target address (also fed to boot_rom)
- cpu_addr  in  16  CPU address bus
- cpu_rd  in  1  CPU read strobe, level, held until rd_ready
- cpu_mio  in  1  1 = memory cycle, 0 = I/O cycle
- last_addr  out  8  registered ROM address to boot_rom
- rom_sel  out  1  1 = bus data mux selects boot_rom bus_out
- rd_ready  out  1  read acknowledge, valid for ROM reads only
- cpu_hold  out  1  stalls CPU
- ext_mem_en  out  1  enables external memory decode
- booted  out  1  sticky; handoff complete
- boot_timeout  out  1  sticky; watchdog fired

Behaviour:
- Reset (async, rst_n=0) values:
  - state=HOLD, last_addr=0x00, rom_sel=0, rd_ready=0, cpu_hold=1, ext_mem_en=0, booted=0, boot_timeout=0.
  - Hold and watchdog counters are 0.
  - Reset asserted mid-operation returns to these values immediately, whatever the state.
- States:
  - HOLD:
    - cpu_hold=1; hold counter increments each cycle.
    - When the counter reaches HOLD_CYCLES-1: if boot_en=1, go to ROM_ACTIVE; otherwise go to DONE with booted=1.
  - ROM_ACTIVE:
    - cpu_hold=0; ext_mem_en=1 only for memory cycles with addr >= ROM_SIZE, since the CPU copies to RAM via I/O SPI.
    - A ROM hit is cpu_rd=1, cpu_mio=1, cpu_addr < ROM_SIZE, and no ack pending.
    - On a ROM hit, last_addr <= cpu_addr[7:0] and rom_sel=1 from the next cycle.
    - rd_ready pulses for exactly one cycle, the cycle after last_addr updates. That gives 2-cycle read latency; data is valid while rd_ready=1.
    - rom_sel stays asserted until cpu_rd drops.
    - Back-to-back reads with cpu_rd held and the address changing after rd_ready are each served with their own 2-cycle latency.
  - HANDOFF:
    - Entered when, in ROM_ACTIVE, cpu_rd=1, cpu_mio=1 and cpu_addr==ram_start. Comparison uses registered state; evaluated when the read starts.
    - On entry: rom_sel forced 0 and ext_mem_en=1, so this read is served by external memory.
    - Next cycle: go to DONE with booted=1.
  - DONE:
    - Terminal until reset. ext_mem_en=1, rom_sel=0, rd_ready=0, cpu_hold=0.
    - ROM-window addresses now go to external memory.
- Watchdog:
  - Counts every cycle in ROM_ACTIVE and saturates.
  - At all-ones: boot_timeout=1, then go to DONE with booted=1.
  - If a ROM read is in flight, it is aborted: rd_ready is not issued and ext_mem_en takes over.
- Simultaneous events: a handoff match beats a watchdog expiry in the same cycle, so boot_timeout stays 0.
- ram_start < ROM_SIZE: handoff match takes priority over the ROM hit.
- I/O cycles (cpu_mio=0) never touch last_addr, rom_sel or rd_ready in any state.
- last_addr retains its last value after DONE.

Decomposition:
- Shared package holds:
  - state encoding: HOLD=2'd0, ROM_ACTIVE=2'd1, HANDOFF=2'd2, DONE=2'd3
  - ROM window size constant
- One sub-module: `boot_wdt`, a saturating counter with enable/clear and a terminal flag, reusable elsewhere.
- The FSM and address latch stay in the top module.

Test Plan:
- Reset, boot_en=1, HOLD_CYCLES=16 -> cpu_hold=1 for exactly 16 cycles after rst_n rises, then 0; ext_mem_en=0 throughout hold.
- Memory read at 0x0004 -> last_addr=0x04 the next cycle; rd_ready single pulse one cycle later; rom_sel=1 until cpu_rd drops.
- ram_start=0x0400, memory read at 0x0400 -> rom_sel=0 and ext_mem_en=1 that cycle; booted=1 the next cycle; a later read at 0x0004 gives rom_sel=0.
- boot_en=0 -> after 16 hold cycles, booted=1 and ext_mem_en=1, and ROM is never selected.
- TIMEOUT_W=4 with no handoff -> boot_timeout=1 and booted=1 after 15 ROM_ACTIVE cycles; a read in flight gets no rd_ready.
- rst_n pulsed low mid-read in ROM_ACTIVE -> all outputs return to reset values asynchronously, and the 16-cycle hold sequence restarts.
